// File: rtl/axi_mem_pkg.sv
// Shared constants and FSM encodings for the AXI memory slave.
package axi_mem_pkg;

   localparam int BEAT_W   = 256;          // bits per beat / memory word
   localparam int STRB_W   = BEAT_W / 8;   // byte enables per beat
   localparam int BYTE_OFS = 5;            // log2(bytes per beat)

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } wr_state_e;

   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_FETCH = 2'd1,
      R_DATA  = 2'd2
   } rd_state_e;

endpackage

// File: rtl/axi_mem_ram.sv
// DEPTH x 256 simple dual-port RAM: byte-enabled write port, registered read.
// Read-before-write: a same-edge read and write of one word returns old data.
module axi_mem_ram
   import axi_mem_pkg::*;
#(
   parameter int DEPTH = 1024,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [BEAT_W-1:0] wdata,
   input  logic [STRB_W-1:0] wstrb,
   input  logic              re,
   input  logic [IDX_W-1:0]  raddr,
   output logic [BEAT_W-1:0] rdata
);

   logic [BEAT_W-1:0] mem [DEPTH];

   // byte-lane gated write
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // synchronous read; output holds while re is low
   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI-style INCR burst memory slave with independent read and write FSMs.
module axi_mem_slave
   import axi_mem_pkg::*;
#(
   parameter int ADDR_W = 29,
   parameter int DEPTH  = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] s_axi_awaddr,
   input  logic [7:0]        s_axi_awlen,
   input  logic              s_axi_awvalid,
   output logic              s_axi_awready,
   input  logic [BEAT_W-1:0] s_axi_wdata,
   input  logic [STRB_W-1:0] s_axi_wstrb,
   input  logic              s_axi_wlast,
   input  logic              s_axi_wvalid,
   output logic              s_axi_wready,
   output logic [1:0]        s_axi_bresp,
   output logic              s_axi_bvalid,
   input  logic              s_axi_bready,
   input  logic [ADDR_W-1:0] s_axi_araddr,
   input  logic [7:0]        s_axi_arlen,
   input  logic              s_axi_arvalid,
   output logic              s_axi_arready,
   output logic [BEAT_W-1:0] s_axi_rdata,
   output logic [1:0]        s_axi_rresp,
   output logic              s_axi_rlast,
   output logic              s_axi_rvalid,
   input  logic              s_axi_rready
);

   localparam int IDX_W = $clog2(DEPTH);
   // word address plus one spare bit so a burst running past the top never wraps into range
   localparam int WA_W = ADDR_W - BYTE_OFS + 1;
   localparam logic [WA_W-1:0] DEPTH_W = WA_W'(DEPTH);

   wr_state_e         w_state, w_next;
   logic [WA_W-1:0]   w_word;
   logic [7:0]        w_len, w_cnt;
   logic              w_err;
   rd_state_e         r_state, r_next;
   logic [WA_W-1:0]   r_word;
   logic [7:0]        r_len, r_cnt;
   logic [BEAT_W-1:0] ram_q;

   logic w_hs, w_in_range, w_final, beat_err;
   logic r_hs, r_in_range, r_final;
   logic addr_lsb_unused;

   assign addr_lsb_unused = ^{s_axi_awaddr[BYTE_OFS-1:0], s_axi_araddr[BYTE_OFS-1:0]};

   assign w_hs       = (w_state == W_DATA) && s_axi_wvalid;
   assign w_in_range = w_word < DEPTH_W;
   assign w_final    = w_cnt == w_len;
   assign beat_err   = !w_in_range || (s_axi_wlast != w_final);

   assign r_hs       = (r_state == R_DATA) && s_axi_rready;
   assign r_in_range = r_word < DEPTH_W;
   assign r_final    = r_cnt == r_len;

   // write state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) w_state <= W_IDLE;
      else        w_state <= w_next;
   end

   // write next state: burst length is counted, wlast only feeds the error flag
   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE:  if (s_axi_awvalid)        w_next = W_DATA;
         W_DATA:  if (w_hs && w_final)      w_next = W_RESP;
         W_RESP:  if (s_axi_bready)         w_next = W_IDLE;
         default:                           w_next = W_IDLE;
      endcase
   end

   // write outputs
   always_comb begin
      s_axi_awready = (w_state == W_IDLE);
      s_axi_wready  = (w_state == W_DATA);
      s_axi_bvalid  = (w_state == W_RESP);
      s_axi_bresp   = (w_state == W_RESP && w_err) ? RESP_SLVERR : RESP_OKAY;
   end

   // write burst bookkeeping: address, beat count, sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_word <= '0;
         w_len  <= '0;
         w_cnt  <= '0;
         w_err  <= 1'b0;
      end else if (w_state == W_IDLE && s_axi_awvalid) begin
         w_word <= {1'b0, s_axi_awaddr[ADDR_W-1:BYTE_OFS]};
         w_len  <= s_axi_awlen;
         w_cnt  <= '0;
         w_err  <= 1'b0;
      end else if (w_hs) begin
         w_word <= w_word + 1'b1;
         w_cnt  <= w_cnt + 1'b1;
         w_err  <= w_err | beat_err;
      end
   end

   // read state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= R_IDLE;
      else        r_state <= r_next;
   end

   // read next state: every beat takes a fetch cycle then a data cycle
   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (s_axi_arvalid) r_next = R_FETCH;
         R_FETCH:                    r_next = R_DATA;
         R_DATA:  if (r_hs)          r_next = r_final ? R_IDLE : R_FETCH;
         default:                    r_next = R_IDLE;
      endcase
   end

   // read outputs; ram_q only updates in R_FETCH, so payload holds under backpressure
   always_comb begin
      s_axi_arready = (r_state == R_IDLE);
      s_axi_rvalid  = (r_state == R_DATA);
      s_axi_rlast   = (r_state == R_DATA) && r_final;
      s_axi_rresp   = (r_state == R_DATA && !r_in_range) ? RESP_SLVERR : RESP_OKAY;
      s_axi_rdata   = (r_state == R_DATA && r_in_range) ? ram_q : '0;
   end

   // read burst bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word <= '0;
         r_len  <= '0;
         r_cnt  <= '0;
      end else if (r_state == R_IDLE && s_axi_arvalid) begin
         r_word <= {1'b0, s_axi_araddr[ADDR_W-1:BYTE_OFS]};
         r_len  <= s_axi_arlen;
         r_cnt  <= '0;
      end else if (r_hs) begin
         r_word <= r_word + 1'b1;
         r_cnt  <= r_cnt + 1'b1;
      end
   end

   axi_mem_ram #(.DEPTH(DEPTH)) u_ram (
      .clk   (clk),
      .we    (w_hs && w_in_range),
      .waddr (w_word[IDX_W-1:0]),
      .wdata (s_axi_wdata),
      .wstrb (s_axi_wstrb),
      .re    (r_state == R_FETCH),
      .raddr (r_word[IDX_W-1:0]),
      .rdata (ram_q)
   );

endmodule

// File: tb/tb_axi_mem_slave.sv
// Randomized self-checking bench for axi_mem_slave against a byte-level memory model.
module tb_axi_mem_slave;
   import axi_mem_pkg::*;

   localparam int ADDR_W = 29;
   localparam int DEPTH  = 1024;

   logic              clk, rst_n;
   logic [ADDR_W-1:0] awaddr, araddr;
   logic [7:0]        awlen, arlen;
   logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic              arvalid, arready, rlast, rvalid, rready;
   logic [255:0]      wdata, rdata;
   logic [31:0]       wstrb;
   logic [1:0]        bresp, rresp;

   int checks = 0;
   int errors = 0;

   // model: data and known-byte mask per word index
   logic [255:0] m_dat [int];
   logic [255:0] m_msk [int];
   logic [255:0] wd_q [256];
   logic [31:0]  ws_q [256];

   axi_mem_slave #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
      .s_axi_wready(wready), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast), .s_axi_rvalid(rvalid),
      .s_axi_rready(rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] rnd256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [255:0] strb2mask(input logic [31:0] s);
      logic [255:0] m;
      for (int i = 0; i < 32; i++) m[8*i +: 8] = {8{s[i]}};
      return m;
   endfunction

   function automatic logic [ADDR_W-1:0] waddr_of(input int wi);
      logic [ADDR_W-1:0] a;
      a = ADDR_W'(wi) << 5;
      a[4:0] = 5'($urandom);
      return a;
   endfunction

   // full write burst from wd_q/ws_q; bad_last inverts wlast on that beat (-1: none)
   task automatic axi_write(input logic [ADDR_W-1:0] a, input int len, input int bad_last,
                            input int b_stall, input string nm);
      int t, wi;
      logic [1:0] exp_resp, got;
      logic [255:0] mk;
      exp_resp = RESP_OKAY;
      awaddr = a; awlen = 8'(len); awvalid = 1'b1;
      t = 0;
      while (!awready && t < 50) begin tick(); t++; end
      checks++;
      if (awready !== 1'b1) begin $display("FAIL %s aw_timeout got %b exp 1", nm, awready); errors++; end
      tick(); awvalid = 1'b0;
      for (int b = 0; b <= len; b++) begin
         wi = int'(a[ADDR_W-1:5]) + b;
         if ($urandom_range(0, 3) == 0) tick();
         wdata = wd_q[b]; wstrb = ws_q[b];
         wlast = (b == len) ^ (b == bad_last);
         wvalid = 1'b1;
         t = 0;
         while (!wready && t < 50) begin tick(); t++; end
         checks++;
         if (wready !== 1'b1) begin $display("FAIL %s w_timeout beat %0d got %b exp 1", nm, b, wready); errors++; end
         tick(); wvalid = 1'b0; wlast = 1'b0;
         if (wi >= DEPTH) exp_resp = RESP_SLVERR;
         else begin
            mk = strb2mask(ws_q[b]);
            if (!m_dat.exists(wi)) begin m_dat[wi] = '0; m_msk[wi] = '0; end
            m_dat[wi] = (m_dat[wi] & ~mk) | (wd_q[b] & mk);
            m_msk[wi] = m_msk[wi] | mk;
         end
         if (b == bad_last) exp_resp = RESP_SLVERR;
      end
      bready = 1'b0;
      t = 0;
      while (!bvalid && t < 50) begin tick(); t++; end
      checks++;
      if (bvalid !== 1'b1) begin $display("FAIL %s b_timeout got %b exp 1", nm, bvalid); errors++; end
      got = bresp;
      for (int s = 0; s < b_stall; s++) begin
         tick();
         checks++;
         if (bvalid !== 1'b1 || bresp !== got) begin
            $display("FAIL %s b_stable bvalid %b bresp %b exp 1 %b", nm, bvalid, bresp, got); errors++;
         end
      end
      bready = 1'b1; tick(); bready = 1'b0;
      checks++;
      if (got !== exp_resp) begin $display("FAIL %s bresp got %b exp %b", nm, got, exp_resp); errors++; end
      checks++;
      if (bvalid !== 1'b0) begin $display("FAIL %s b_drop got %b exp 0", nm, bvalid); errors++; end
   endtask

   // read burst; stall_beat holds rready low for stall_n cycles on that beat
   task automatic axi_read(input logic [ADDR_W-1:0] a, input int len, input int stall_beat,
                           input int stall_n, input string nm);
      int t, wi;
      logic [255:0] cd, mk;
      logic [1:0] cr;
      logic cl;
      araddr = a; arlen = 8'(len); arvalid = 1'b1; rready = 1'b0;
      t = 0;
      while (!arready && t < 50) begin tick(); t++; end
      checks++;
      if (arready !== 1'b1) begin $display("FAIL %s ar_timeout got %b exp 1", nm, arready); errors++; end
      tick(); arvalid = 1'b0;
      for (int b = 0; b <= len; b++) begin
         wi = int'(a[ADDR_W-1:5]) + b;
         t = 1;
         while (!rvalid && t < 20) begin tick(); t++; end
         checks++;
         if (t != 2) begin $display("FAIL %s latency beat %0d got %0d exp 2", nm, b, t); errors++; end
         checks++;
         if (rlast !== (b == len)) begin $display("FAIL %s rlast beat %0d got %b exp %b", nm, b, rlast, b == len); errors++; end
         if (wi >= DEPTH) begin
            checks++;
            if (rdata !== '0 || rresp !== RESP_SLVERR) begin
               $display("FAIL %s oor beat %0d rdata %h rresp %b exp 0 %b", nm, b, rdata, rresp, RESP_SLVERR); errors++;
            end
         end else begin
            checks++;
            if (rresp !== RESP_OKAY) begin $display("FAIL %s rresp beat %0d got %b exp %b", nm, b, rresp, RESP_OKAY); errors++; end
            if (m_msk.exists(wi)) begin
               mk = m_msk[wi];
               checks++;
               if ((rdata & mk) !== (m_dat[wi] & mk)) begin
                  $display("FAIL %s rdata beat %0d got %h exp %h", nm, b, rdata & mk, m_dat[wi] & mk); errors++;
               end
            end
         end
         cd = rdata; cr = rresp; cl = rlast;
         if (b == stall_beat) begin
            for (int s = 0; s < stall_n; s++) begin
               tick();
               checks++;
               if (rvalid !== 1'b1 || rdata !== cd || rresp !== cr || rlast !== cl) begin
                  $display("FAIL %s r_stable beat %0d rvalid %b rdata %h exp %h", nm, b, rvalid, rdata, cd); errors++;
               end
            end
         end else if ($urandom_range(0, 2) == 0) begin
            tick();
         end
         rready = 1'b1; tick(); rready = 1'b0;
      end
      checks++;
      if (rvalid !== 1'b0 || arready !== 1'b1) begin
         $display("FAIL %s r_end rvalid %b arready %b exp 0 1", nm, rvalid, arready); errors++;
      end
   endtask

   task automatic check_reset_outputs(input string nm);
      checks++;
      if ({awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp} !== 10'b11_0000_0000 || rdata !== '0) begin
         $display("FAIL %s aw %b ar %b w %b b %b r %b rl %b br %b rr %b rd %h exp 1 1 0 0 0 0 00 00 0",
                  nm, awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, rdata);
         errors++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      awaddr = '0; awlen = '0; awvalid = 0; wdata = '0; wstrb = '0; wlast = 0; wvalid = 0; bready = 0;
      araddr = '0; arlen = '0; arvalid = 0; rready = 0;
      tick(); tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      wd_q[0] = {32{8'hA5}}; ws_q[0] = '1;
      axi_write(29'h40, 0, -1, 0, "single_wr");
      axi_read(29'h40, 0, -1, 0, "single_rd");
   endtask

   task automatic test_strobe();
      for (int b = 0; b < 4; b++) begin wd_q[b] = rnd256(); ws_q[b] = '1; end
      axi_write(29'h100, 3, -1, 0, "strb_fill");
      for (int b = 0; b < 4; b++) begin wd_q[b] = rnd256(); ws_q[b] = '1; end
      ws_q[1] = 32'h0000_000F;
      axi_write(29'h100, 3, -1, 0, "strb_wr");
      axi_read(29'h100, 3, -1, 0, "strb_rd");
   endtask

   task automatic test_out_of_range();
      wd_q[0] = rnd256(); ws_q[0] = '1;
      axi_write(29'h0, 0, -1, 0, "oor_word0");
      wd_q[0] = ~wd_q[0];
      axi_write(29'h8000, 0, -1, 0, "oor_wr");
      axi_read(29'h0, 0, -1, 0, "oor_alias_rd");
      axi_read(29'h8000, 0, -1, 0, "oor_rd");
      for (int b = 0; b < 4; b++) begin wd_q[b] = rnd256(); ws_q[b] = '1; end
      axi_write(waddr_of(DEPTH - 2), 3, -1, 0, "oor_cross_wr");
      axi_read(waddr_of(DEPTH - 2), 3, -1, 0, "oor_cross_rd");
   endtask

   task automatic test_wlast();
      for (int b = 0; b < 4; b++) begin wd_q[b] = rnd256(); ws_q[b] = '1; end
      axi_write(29'h400, 3, 1, 0, "wlast_early");
      for (int b = 0; b < 4; b++) begin wd_q[b] = rnd256(); ws_q[b] = 32'($urandom); end
      axi_write(29'h400, 3, 3, 0, "wlast_missing");
      axi_read(29'h400, 3, -1, 0, "wlast_rd");
   endtask

   task automatic test_backpressure();
      for (int b = 0; b < 4; b++) begin wd_q[b] = rnd256(); ws_q[b] = '1; end
      axi_write(29'h600, 3, -1, 3, "bp_wr");
      axi_read(29'h600, 3, 1, 5, "bp_rd");
   endtask

   task automatic test_same_word();
      logic [255:0] old_d, new_d;
      old_d = rnd256(); new_d = rnd256();
      wd_q[0] = old_d; ws_q[0] = '1;
      axi_write(29'h280, 0, -1, 0, "same_pre");
      awaddr = 29'h280; awlen = 0; awvalid = 1'b1; tick(); awvalid = 1'b0;
      araddr = 29'h280; arlen = 0; arvalid = 1'b1; tick(); arvalid = 1'b0;
      wdata = new_d; wstrb = '1; wlast = 1'b1; wvalid = 1'b1; tick(); wvalid = 1'b0; wlast = 1'b0;
      checks++;
      if (rvalid !== 1'b1 || rdata !== old_d) begin
         $display("FAIL same_word_old rvalid %b rdata %h exp 1 %h", rvalid, rdata, old_d); errors++;
      end
      rready = 1'b1;
      checks++;
      if (bvalid !== 1'b1 || bresp !== RESP_OKAY) begin
         $display("FAIL same_word_b bvalid %b bresp %b exp 1 00", bvalid, bresp); errors++;
      end
      bready = 1'b1; tick(); rready = 1'b0; bready = 1'b0;
      m_dat[20] = new_d; m_msk[20] = '1;
      axi_read(29'h280, 0, -1, 0, "same_new_rd");
   endtask

   task automatic test_concurrent();
      for (int b = 0; b < 6; b++) begin wd_q[b] = rnd256(); ws_q[b] = '1; end
      fork
         axi_write(29'h1000, 5, -1, 1, "conc_wr");
         axi_read(29'h600, 3, 2, 2, "conc_rd");
      join
      axi_read(29'h1000, 5, -1, 0, "conc_chk");
   endtask

   task automatic test_random();
      int wi, len;
      for (int n = 0; n < 20; n++) begin
         wi  = $urandom_range(0, DEPTH - 1);
         len = $urandom_range(0, 7);
         for (int b = 0; b <= len; b++) begin
            wd_q[b] = rnd256();
            ws_q[b] = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'($urandom);
         end
         axi_write(waddr_of(wi), len, -1, $urandom_range(0, 2), "rand_wr");
         axi_read(waddr_of(wi), len, $urandom_range(0, len), $urandom_range(0, 3), "rand_rd");
      end
   endtask

   task automatic test_reset_midburst();
      awaddr = 29'h200; awlen = 3; awvalid = 1'b1; tick(); awvalid = 1'b0;
      wdata = rnd256(); wstrb = '1; wlast = 1'b0; wvalid = 1'b1; tick();
      wdata = rnd256(); wvalid = 1'b1;
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("reset_mid");
      wvalid = 1'b0;
      tick(); tick();
      check_reset_outputs("reset_hold");
      rst_n = 1'b1;
      tick();
      m_dat.delete(); m_msk.delete();
      wd_q[0] = rnd256(); ws_q[0] = '1;
      axi_write(29'h200, 0, -1, 0, "after_reset_wr");
      axi_read(29'h200, 0, -1, 0, "after_reset_rd");
   endtask

   initial begin
      test_reset();
      test_single();
      test_strobe();
      test_out_of_range();
      test_wlast();
      test_backpressure();
      test_same_word();
      test_concurrent();
      test_random();
      test_reset_midburst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 Parameter ADDR_W, default 29, byte-address width of AW/AR channels.
REQ-002 Parameter DEPTH, default 1024, number of 256-bit memory words (power of two).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 s_axi_awaddr  in  ADDR_W  write burst start byte address.
REQ-007 s_axi_awlen  in  8  write beats minus one.
REQ-008 s_axi_awvalid / s_axi_awready  in / out  1 each  write-address handshake.
REQ-009 s_axi_wdata  in  256  write beat data.
REQ-010 s_axi_wstrb  in  32  byte enables, bit i gates wdata[8i+7:8i].
REQ-011 s_axi_wlast  in  1  final write beat marker.
REQ-012 s_axi_wvalid / s_axi_wready  in / out  1 each  write-data handshake.
REQ-013 s_axi_bresp  out  2  write response, 00 OKAY, 10 SLVERR.
REQ-014 s_axi_bvalid / s_axi_bready  out / in  1 each  write-response handshake.
REQ-015 s_axi_araddr  in  ADDR_W  read burst start byte address.
REQ-016 s_axi_arlen  in  8  read beats minus one.
REQ-017 s_axi_arvalid / s_axi_arready  in / out  1 each  read-address handshake.
REQ-018 s_axi_rdata  out  256  read beat data.
REQ-019 s_axi_rresp  out  2  per-beat read response, same encoding as bresp.
REQ-020 s_axi_rlast  out  1  asserted on the final read beat only.
REQ-021 s_axi_rvalid / s_axi_rready  out / in  1 each  read-data handshake.

Function
REQ-022 Beats SHALL be full 256-bit words, burst type INCR only; word index = addr[5+log2(DEPTH)-1:5], advancing by one per beat; addr[4:0] ignored.
REQ-023 Write FSM SHALL be W_IDLE (awready=1) -> W_DATA on AW handshake (latch addr, len; beat count 0) -> W_RESP after beat count reaches awlen+1 -> W_IDLE on B handshake.
REQ-024 In W_DATA, wready SHALL be 1; each W handshake writes strobed bytes to the current word the same edge.
REQ-025 bresp SHALL be SLVERR if any beat word index is >= DEPTH (those beats dropped) or wlast disagrees with the final-beat position; otherwise OKAY.
REQ-026 The write burst SHALL end on the beat count, never on wlast alone.
REQ-027 Read FSM SHALL be R_IDLE (arready=1) -> R_FETCH (one-cycle synchronous RAM read) -> R_DATA (rvalid=1, data held stable until rready) -> R_FETCH for the next beat, or R_IDLE after the last beat handshakes.
REQ-028 First-beat latency SHALL be 2 cycles from AR handshake to rvalid; each subsequent beat SHALL be 2 cycles after the previous R handshake.
REQ-029 Out-of-range read beats SHALL return rdata=0 with rresp=SLVERR.
REQ-030 Read and write channels SHALL operate concurrently; a same-cycle read and write of one word SHALL return the old data.
REQ-031 Backpressure (bready=0 or rready=0 for any duration) SHALL hold bvalid/rvalid and all payload outputs unchanged.

Reset
REQ-032 While rst_n=0, both FSMs SHALL be IDLE; awready=arready=1, wready=bvalid=rvalid=rlast=0, bresp=rresp=00, rdata=0; memory contents undefined; any burst in flight is abandoned with no response.

Structure
REQ-033 Package axi_mem_pkg SHALL hold the RESP_OKAY/RESP_SLVERR constants, the beat width (256), strobe width (32), and the FSM state encodings.
REQ-034 Sub-module axi_mem_ram SHALL implement the DEPTH x 256 simple dual-port RAM (one byte-enabled write port, one synchronous read port).

Verification
REQ-035 Single write to 0x40 (all strobes, data A5..A5), then read 0x40 len 0 -> bresp=00; rdata=A5..A5; rresp=00; rlast=1; rvalid 2 cycles after AR handshake.
REQ-036 4-beat write at 0x100 with wstrb=0x0000000F on beat 2, then 4-beat read -> beat 2 changes only bytes 0-3; rlast only on beat 4.
REQ-037 Write to word DEPTH (addr 0x8000 at DEPTH=1024) -> bresp=10, memory unchanged; read of the same address -> rdata=0, rresp=10.
REQ-038 Hold rready=0 for 5 cycles mid-burst, and bready=0 for 3 cycles -> rvalid/rdata and bvalid/bresp stable; no beat lost or duplicated.
REQ-039 Drive rst_n low during beat 2 of a 4-beat write -> all outputs take their reset values; a new single-beat write afterwards completes with bresp=00.
